// File: rtl/ddr_traffic_pkg.sv
// Shared types and constants for the DDR write/read-back traffic checker.
package ddr_traffic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_INIT,
    ST_WRITE,
    ST_READ,
    ST_DONE
  } state_e;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  localparam logic MODE_INC  = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

  // Galois step, shift right, taps x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/ddr_pattern_gen.sv
// Beat pattern source shared by the write and read phases: incrementing count or
// 32-bit LFSR. The LFSR is only built when TRAFFIC_CHECKER_LFSR_EN is defined.
module ddr_pattern_gen
  import ddr_traffic_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              reseed,
  input  logic              advance,
  input  logic              mode,
  output logic [DATA_W-1:0] pattern
);

  logic [DATA_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reseed)       cnt_d = '0;
    else if (advance) cnt_d = cnt_q + DATA_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

`ifdef TRAFFIC_CHECKER_LFSR_EN
  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (reseed)       lfsr_d = LFSR_SEED;
    else if (advance) lfsr_d = lfsr_step(lfsr_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign pattern = (mode == MODE_LFSR) ? lfsr_q[DATA_W-1:0] : cnt_q;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign pattern     = cnt_q;
`endif

endmodule

// File: rtl/ddr_traffic_checker.sv
// Write-then-read-back traffic generator and checker for the slowDDR3 user port.
// Define TRAFFIC_CHECKER_LFSR_EN to enable the LFSR pattern (mode input); otherwise incrementing only.
module ddr_traffic_checker
  import ddr_traffic_pkg::*;
#(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       ADDR_W      = 27,
  parameter int unsigned       CNT_W       = 17,
  parameter int unsigned       SEL_W       = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter logic [ADDR_W-1:0] ADDR_STRIDE = ADDR_W'(1),
  parameter int unsigned       ERR_W       = 16,
  parameter logic [31:0]       LFSR_SEED   = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              mode,
  input  logic              init_fin,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [DATA_W-1:0] wr_payload,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [DATA_W-1:0] rd_payload,
  output logic [ADDR_W-1:0] address,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  first_err_idx
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d, idx_q, idx_d, first_err_idx_q, first_err_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic              mode_q, mode_d;
  logic              wr_valid_q, wr_valid_d, rd_ready_q, rd_ready_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic              reseed, advance, wr_acc, rd_acc, last_beat;
  logic [DATA_W-1:0] pattern;

  assign wr_acc    = wr_valid_q && wr_ready;
  assign rd_acc    = rd_ready_q && rd_valid;
  assign last_beat = (idx_q == len_q - CNT_W'(1));

  ddr_pattern_gen #(
    .DATA_W    (DATA_W),
    .LFSR_SEED (LFSR_SEED)
  ) u_pattern (
    .clk     (clk),
    .resetn  (resetn),
    .reseed  (reseed),
    .advance (advance),
    .mode    (mode_q),
    .pattern (pattern)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d         = state_q;
    len_d           = len_q;
    mode_d          = mode_q;
    idx_d           = idx_q;
    addr_d          = addr_q;
    err_cnt_d       = err_cnt_q;
    first_err_idx_d = first_err_idx_q;
    done_d          = done_q;
    pass_d          = pass_q;
    reseed          = 1'b0;
    advance         = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          len_d           = len;
          mode_d          = mode;
          idx_d           = '0;
          addr_d          = BASE_ADDR;
          err_cnt_d       = '0;
          first_err_idx_d = '0;
          done_d          = 1'b0;
          pass_d          = 1'b0;
          reseed          = 1'b1;
          if (len == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_WAIT_INIT;
          end
        end
      end
      ST_WAIT_INIT: if (init_fin) state_d = ST_WRITE;
      ST_WRITE: begin
        if (wr_acc) begin
          if (last_beat) begin
            idx_d   = '0;
            addr_d  = BASE_ADDR;
            reseed  = 1'b1;
            state_d = ST_READ;
          end else begin
            idx_d   = idx_q + CNT_W'(1);
            addr_d  = addr_q + ADDR_STRIDE;
            advance = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (rd_acc) begin
          if (rd_payload != pattern) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
            // Saturation never returns to zero, so zero means no earlier mismatch.
            if (err_cnt_q == '0) first_err_idx_d = idx_q;
          end
          idx_d   = idx_q + CNT_W'(1);
          addr_d  = addr_q + ADDR_STRIDE;
          advance = 1'b1;
          if (last_beat) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == '0);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wr_valid_d = (state_d == ST_WRITE);
    rd_ready_d = (state_d == ST_READ);
    busy_d     = (state_d == ST_WAIT_INIT) || (state_d == ST_WRITE) || (state_d == ST_READ);
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= ST_IDLE;
      len_q           <= '0;
      mode_q          <= MODE_INC;
      idx_q           <= '0;
      addr_q          <= BASE_ADDR;
      err_cnt_q       <= '0;
      first_err_idx_q <= '0;
      wr_valid_q      <= 1'b0;
      rd_ready_q      <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      mode_q          <= mode_d;
      idx_q           <= idx_d;
      addr_q          <= addr_d;
      err_cnt_q       <= err_cnt_d;
      first_err_idx_q <= first_err_idx_d;
      wr_valid_q      <= wr_valid_d;
      rd_ready_q      <= rd_ready_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
    end
  end

  assign wr_valid      = wr_valid_q;
  assign wr_payload    = pattern;
  assign rd_ready      = rd_ready_q;
  assign address       = addr_q;
  assign sel           = '0;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_err_idx_q;

endmodule

// File: doc/ddr_traffic_checker.md
# ddr_traffic_checker

Synthesizable write-then-read-back traffic generator and checker for the slowDDR3 user interface (sysIO_* ports). It replaces the bench-only incrementing-pattern loop with a parametrised on-chip block. The block waits for DDR init to finish, writes a programmable number of beats, reads them back, and checks every beat against an incrementing or LFSR pattern. It reports an error count and the index of the first mismatch. It sits between board control logic (start/status) and the slowDDR3 controller.

## Interface
Parameters:
- DATA_W, 16, payload width (1..32)
- ADDR_W, 27, user address width
- CNT_W, 17, beat index/length width
- SEL_W, 2, byte-select width; sel driven constant zero
- BASE_ADDR, 0, address of beat 0
- ADDR_STRIDE, 1, address increment per beat
- ERR_W, 16, error counter width (saturating)
- LFSR_SEED, 32'h0000_0001, non-zero LFSR seed

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; launches a run from IDLE or DONE
- len  in  CNT_W  beats per phase; sampled on accepted start
- mode  in  1  0 = incrementing, 1 = LFSR; sampled on accepted start
- init_fin  in  1  controller init complete (sysIO_initFin)
- wr_valid  out  1  to sysIO_dataWr_valid
- wr_ready  in  1  from sysIO_dataWr_ready
- wr_payload  out  DATA_W  to sysIO_dataWr_payload
- rd_valid  in  1  from sysIO_dataRd_valid
- rd_ready  out  1  to sysIO_dataRd_ready
- rd_payload  in  DATA_W  from sysIO_dataRd_payload
- address  out  ADDR_W  to sysIO_address
- sel  out  SEL_W  to sysIO_sel, constant 0
- busy  out  1  run in progress
- done  out  1  run finished; held until next accepted start
- pass  out  1  valid when done: err_cnt == 0
- err_cnt  out  ERR_W  mismatching read beats, saturates at all-ones
- first_err_idx  out  CNT_W  beat index of the first mismatch; 0 if none

## Operation
- States: IDLE, WAIT_INIT, WRITE, READ, DONE.
- IDLE/DONE + start:
  - Latch len and mode; clear idx, err_cnt, first_err_idx, done; reseed the pattern.
  - If len == 0, go to DONE with pass = 1.
  - Otherwise go to WAIT_INIT.
- WAIT_INIT:
  - Go to WRITE in the first cycle that init_fin = 1.
  - init_fin is ignored after leaving WAIT_INIT.
- WRITE:
  - wr_valid = 1, wr_payload = pattern(idx), address = BASE_ADDR + idx*ADDR_STRIDE (mod 2^ADDR_W).
  - A beat is accepted when wr_valid && wr_ready; idx increments and the pattern advances.
  - On acceptance with idx == len-1: idx <= 0, reseed the pattern, go to READ.
- READ:
  - rd_ready = 1; address tracks idx as in WRITE.
  - A beat is accepted when rd_valid && rd_ready.
  - rd_payload != expected: err_cnt++ (saturating); on the first mismatch, capture first_err_idx = idx.
  - On acceptance with idx == len-1: go to DONE.
- DONE: done = 1; start is accepted as in IDLE.
- start in WAIT_INIT, WRITE or READ is ignored.
- Incrementing pattern: idx zero-extended or truncated to DATA_W. Wrap follows from truncation: idx 65536 with DATA_W = 16 yields 0.
- LFSR pattern:
  - 32-bit Galois register, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003), shift right.
  - Payload is the low DATA_W bits.
  - The register advances once per accepted beat.

## Timing
- Reset values: state IDLE; wr_valid 0, rd_ready 0, busy 0, done 0, pass 0, err_cnt 0, first_err_idx 0, address BASE_ADDR, wr_payload 0, sel 0.
- All outputs are registered.
- WAIT_INIT -> WRITE: wr_valid rises the cycle after init_fin is sampled high.
- Once wr_valid is high, wr_payload and address are stable until acceptance. The next beat is presented the following cycle, giving one beat per cycle when wr_ready stays high.
- Last write accepted in cycle N: rd_ready = 1 and address = BASE_ADDR in cycle N+1.
- err_cnt/first_err_idx update the cycle after the mismatching beat.
- Last read accepted in cycle M: done = 1, busy = 0, pass valid in cycle M+1.
- rd_valid while not in READ is ignored and not counted.
- resetn asserted mid-run: immediate return to reset values. No drain; the controller is reset alongside.

## Configuration
- TRAFFIC_CHECKER_LFSR_EN defined: LFSR generator present; mode selects the pattern.
- Not defined: LFSR logic is removed, mode is ignored, and the pattern is always incrementing.

## Structure
- Package ddr_traffic_pkg: state enum, LFSR mask constant 32'h8020_0003, mode encodings.
- Sub-module ddr_pattern_gen provides both patterns: inputs clk, resetn, reseed, advance, mode; output pattern [DATA_W-1:0]. It is instantiated once and shared by the write and read phases.

## Test plan
- Incrementing, len=66560, DATA_W=16, behavioural DDR3 model: 66560 writes then reads; read beat 65536 returns 0; done=1, pass=1, err_cnt=0.
- init_fin held low for 500 cycles after start: wr_valid stays 0 until the cycle after init_fin rises.
- LFSR mode, len=1024, wr_ready toggled randomly: payload held while stalled; all reads match; pass=1.
- Model corrupts read beats 10 and 20: err_cnt=2, first_err_idx=10, pass=0.
- len=0 start: done=1 and pass=1 next cycle, with no wr_valid or rd_ready activity; start during WRITE is ignored.
- resetn pulsed low mid-WRITE: all outputs return to reset values asynchronously; a new start completes with pass=1.
